// File: rtl/ap_txn_pkg.sv
// Shared types for the ap_ctrl transaction tracker: FSM states, the record layout
// at default widths, and the record width helper.
package ap_txn_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int ID_W_DEF  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE_WAIT,
        S_FLUSH,
        S_DRAINED
    } state_e;

    // Field order matches rec_data, MSB first.
    typedef struct packed {
        logic                 err;
        logic [ID_W_DEF-1:0]  id;
        logic [CNT_W_DEF-1:0] start_cyc;
        logic [CNT_W_DEF-1:0] latency;
        logic [CNT_W_DEF-1:0] interval;
        logic [CNT_W_DEF-1:0] stall;
    } txn_rec_t;

    function automatic int rec_w(input int cnt_w, input int id_w);
        return 1 + id_w + 4 * cnt_w;
    endfunction

endpackage

// File: rtl/txn_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty/count; a pop in the
// same cycle makes room for a push into a full FIFO.
module txn_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= bump(wr_ptr);
            if (do_rd) rd_ptr <= bump(rd_ptr);
            if (do_wr && !do_rd)      count <= count + CW'(1);
            else if (do_rd && !do_wr) count <= count - CW'(1);
        end
    end

    // NOTE: storage has no reset; empty gates rd_data, so stale contents are never visible.
    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ap_ctrl_txn_tracker.sv
// Watches one HLS top's ap_ctrl_hs handshake and emits one timestamped record per
// completed transaction on a valid/ready stream.
module ap_ctrl_txn_tracker
    import ap_txn_pkg::*;
#(
    parameter  int CNT_W     = 32,
    parameter  int ID_W      = 16,
    parameter  int MAX_OUT   = 4,
    parameter  int REC_DEPTH = 16,
    localparam int REC_W     = rec_w(CNT_W, ID_W)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [REC_W-1:0] rec_data,
    output logic [15:0]      drop_count,
    output logic             protocol_err,
    output logic             busy,
    output logic             drained
);

    localparam int SQ_CW = $clog2(MAX_OUT + 1);
    localparam int RF_CW = $clog2(REC_DEPTH + 1);

    logic [CNT_W-1:0]   cyc, prev_acc_cyc, stall_cnt, acc_interval, q_start, q_int;
    logic               have_prev, acc, dn, sq_push, sq_pop, overflow, drop, finish_q;
    logic [ID_W-1:0]    id;
    logic [2*CNT_W-1:0] sq_wdata, sq_rdata;
    logic               sq_full, sq_empty, rf_full, rf_empty;
    logic [SQ_CW-1:0]   sq_count;
    logic [SQ_CW:0]     remaining;
    logic [RF_CW-1:0]   rf_count;
    logic [REC_W-1:0]   rec_next, rec_pend;
    logic               rec_pend_valid;
    state_e             state;

    assign acc          = ap_start && ap_ready;
    assign dn           = ap_done && ap_continue;
    assign acc_interval = have_prev ? cyc - prev_acc_cyc : '0;
    assign sq_wdata     = {cyc, acc_interval};
    assign q_start      = sq_rdata[2*CNT_W-1:CNT_W];
    assign q_int        = sq_rdata[CNT_W-1:0];

    // Done pops before accept pushes, so a full queue with A and D together cannot overflow.
    assign sq_pop    = dn && !sq_empty;
    assign sq_push   = acc && (!sq_full || dn);
    assign overflow  = acc && sq_full && !dn;
    assign remaining = (SQ_CW+1)'(sq_count) + (SQ_CW+1)'(sq_push) - (SQ_CW+1)'(sq_pop);
    assign drop      = rec_pend_valid && rf_full && !rec_ready;

    assign rec_next = sq_empty
        ? {1'b1, id, cyc, {CNT_W{1'b0}}, {CNT_W{1'b0}}, stall_cnt}
        : {1'b0, id, q_start, cyc - q_start, q_int, stall_cnt};

    assign rec_valid = (rf_count != '0);
    assign busy      = !sq_empty;
    assign drained   = (state == S_DRAINED);

    txn_sync_fifo #(.WIDTH(2*CNT_W), .DEPTH(MAX_OUT)) u_start_q (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (acc),
        .wr_data(sq_wdata),
        .rd_en  (dn),
        .rd_data(sq_rdata),
        .full   (sq_full),
        .empty  (sq_empty),
        .count  (sq_count)
    );

    txn_sync_fifo #(.WIDTH(REC_W), .DEPTH(REC_DEPTH)) u_rec_fifo (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (rec_pend_valid),
        .wr_data(rec_pend),
        .rd_en  (rec_ready),
        .rd_data(rec_data),
        .full   (rf_full),
        .empty  (rf_empty),
        .count  (rf_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            cyc            <= '0;
            prev_acc_cyc   <= '0;
            have_prev      <= 1'b0;
            stall_cnt      <= '0;
            id             <= '0;
            rec_pend_valid <= 1'b0;
            rec_pend       <= '0;
            drop_count     <= '0;
            protocol_err   <= 1'b0;
            finish_q       <= 1'b0;
        end else begin
            cyc <= cyc + CNT_W'(1);
            if (acc) begin
                prev_acc_cyc <= cyc;
                have_prev    <= 1'b1;
            end
            if (ap_done && !ap_continue)
                stall_cnt <= (stall_cnt == '1) ? stall_cnt : stall_cnt + CNT_W'(1);
            else
                stall_cnt <= '0;
            rec_pend_valid <= dn;
            if (dn) begin
                rec_pend <= rec_next;
                id       <= id + ID_W'(1);
            end
            if (drop && drop_count != '1) drop_count <= drop_count + 16'd1;
            if (overflow || (dn && sq_empty)) protocol_err <= 1'b1;
            finish_q <= finish_q || finish;
        end
    end

    // A record still in the one-cycle push stage counts as not yet drained.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else if (state == S_DRAINED) begin
            state <= S_DRAINED;
        end else if (finish || finish_q) begin
            state <= (state == S_FLUSH && sq_empty && rf_empty && !rec_pend_valid)
                     ? S_DRAINED : S_FLUSH;
        end else begin
            case (state)
                S_IDLE:      if (acc) state <= S_ACTIVE;
                S_ACTIVE: begin
                    if (ap_done && !ap_continue)    state <= S_DONE_WAIT;
                    else if (dn && remaining == '0) state <= S_IDLE;
                end
                S_DONE_WAIT: if (dn) state <= (remaining != '0) ? S_ACTIVE : S_IDLE;
                default:     state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ap_ctrl_txn_tracker.sv
// Directed and randomized bench for ap_ctrl_txn_tracker; a 32-bit and an 8-bit
// counter instance share stimulus and are checked against one transaction model.
module tb_ap_ctrl_txn_tracker;
    import ap_txn_pkg::*;

    localparam int MAX_OUT = 4;
    localparam int REC_DEPTH = 16;
    localparam int WW = rec_w(32, 16);
    localparam int NW = rec_w(8, 16);

    logic clock = 1'b0, reset = 1'b1;
    logic ap_start = 1'b0, ap_ready = 1'b1, ap_done = 1'b0, ap_continue = 1'b1;
    logic finish = 1'b0, rec_ready = 1'b0;

    logic          rec_valid_w, perr_w, busy_w, drained_w;
    logic [WW-1:0] rec_data_w;
    logic [15:0]   drop_w;
    logic          rec_valid_n, perr_n, busy_n, drained_n;
    logic [NW-1:0] rec_data_n;
    logic [15:0]   drop_n;

    ap_ctrl_txn_tracker dut_w (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
        .rec_valid(rec_valid_w), .rec_ready(rec_ready), .rec_data(rec_data_w),
        .drop_count(drop_w), .protocol_err(perr_w), .busy(busy_w), .drained(drained_w)
    );

    ap_ctrl_txn_tracker #(.CNT_W(8)) dut_n (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
        .rec_valid(rec_valid_n), .rec_ready(rec_ready), .rec_data(rec_data_n),
        .drop_count(drop_n), .protocol_err(perr_n), .busy(busy_n), .drained(drained_n)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction-level reference model.
    typedef struct { int unsigned start; int unsigned intv; } acc_t;
    typedef struct { bit err; int unsigned id; int unsigned start, lat, intv, stall; } mrec_t;

    acc_t        sq[$];
    mrec_t       rq[$];
    mrec_t       pend;
    bit          pend_v, have_prev, m_perr;
    int unsigned m_cyc, prev_acc, m_stall, m_id, m_drops;

    task automatic model_edge();
        if (reset) begin
            sq.delete(); rq.delete();
            pend_v = 0; have_prev = 0; m_perr = 0;
            m_cyc = 0; prev_acc = 0; m_stall = 0; m_id = 0; m_drops = 0;
            return;
        end
        if (rec_ready && rq.size() > 0) void'(rq.pop_front());
        if (pend_v) begin
            if (rq.size() < REC_DEPTH) rq.push_back(pend);
            else if (m_drops < 65535) m_drops++;
        end
        pend_v = 0;
        if (ap_done && ap_continue) begin
            if (sq.size() == 0) begin
                pend = '{err: 1, id: m_id, start: m_cyc, lat: 0, intv: 0, stall: m_stall};
                m_perr = 1;
            end else begin
                acc_t e = sq.pop_front();
                pend = '{err: 0, id: m_id, start: e.start, lat: m_cyc - e.start,
                         intv: e.intv, stall: m_stall};
            end
            pend_v = 1;
            m_id = (m_id + 1) & 32'hFFFF;
        end
        if (ap_start && ap_ready) begin
            acc_t a;
            a.start = m_cyc;
            a.intv = have_prev ? m_cyc - prev_acc : 0;
            prev_acc = m_cyc;
            have_prev = 1;
            if (sq.size() < MAX_OUT) sq.push_back(a);
            else m_perr = 1;
        end
        m_stall = (ap_done && !ap_continue) ? m_stall + 1 : 0;
        m_cyc++;
    endtask

    function automatic logic [255:0] pack_w(input mrec_t m);
        txn_rec_t r;
        r.err = m.err; r.id = m.id[15:0]; r.start_cyc = m.start;
        r.latency = m.lat; r.interval = m.intv; r.stall = m.stall;
        return 256'(r);
    endfunction

    function automatic logic [255:0] pack_n(input mrec_t m);
        logic [31:0] st = (m.stall > 255) ? 32'd255 : m.stall;
        logic [NW-1:0] v = {m.err, m.id[15:0], m.start[7:0], m.lat[7:0], m.intv[7:0], st[7:0]};
        return 256'(v);
    endfunction

    task automatic compare();
        check("w_valid", 256'(rec_valid_w), 256'(rq.size() != 0));
        check("n_valid", 256'(rec_valid_n), 256'(rq.size() != 0));
        if (rq.size() != 0) begin
            check("w_data", 256'(rec_data_w), pack_w(rq[0]));
            check("n_data", 256'(rec_data_n), pack_n(rq[0]));
        end
        check("w_drop", 256'(drop_w), 256'(m_drops));
        check("n_drop", 256'(drop_n), 256'(m_drops));
        check("w_perr", 256'(perr_w), 256'(m_perr));
        check("n_perr", 256'(perr_n), 256'(m_perr));
        check("w_busy", 256'(busy_w), 256'(sq.size() != 0));
        check("n_busy", 256'(busy_n), 256'(sq.size() != 0));
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare();
    endtask

    task automatic drive(input bit s, input bit d, input bit c, input bit rr);
        ap_start = s; ap_done = d; ap_continue = c; rec_ready = rr;
    endtask

    task automatic do_reset();
        reset = 1'b1; finish = 1'b0;
        drive(0, 0, 1, 0);
        tick();
        reset = 1'b0;
    endtask

    txn_rec_t r;

    initial begin
        @(negedge clock);
        do_reset();
        check("rst_drained", 256'(drained_w), 256'(0));
        check("rst_data", 256'(rec_data_w), 256'(0));

        // Single transaction: A at 10, D at 25.
        for (int c = 0; c <= 30; c++) begin drive(c == 10, c == 25, 1, 0); tick(); end
        r = '{err: 1'b0, id: 16'd0, start_cyc: 32'd10, latency: 32'd15, interval: 32'd0, stall: 32'd0};
        check("s1_rec", 256'(rec_data_w), 256'(r));

        // Overlapping transactions.
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            drive(c == 10 || c == 13 || c == 16, c == 30 || c == 33 || c == 36, 1, 1);
            tick();
            if (c == 10) check("s2_busy_on", 256'(busy_w), 256'(1));
            if (c == 36) check("s2_busy_off", 256'(busy_w), 256'(0));
        end

        // Continue backpressure: done 40..45, continue low 40..44.
        do_reset();
        for (int c = 0; c <= 50; c++) begin
            drive(c == 20, c >= 40 && c <= 45, !(c >= 40 && c <= 44), 0);
            tick();
            if (c >= 40 && c <= 44) check("s3_state", 256'(dut_w.state), 256'(S_DONE_WAIT));
        end
        r = rec_data_w;
        check("s3_stall", 256'(r.stall), 256'(5));
        check("s3_latency", 256'(r.latency), 256'(25));

        // Done with nothing outstanding.
        do_reset();
        for (int c = 0; c <= 15; c++) begin drive(0, c == 5, 1, 0); tick(); end
        r = rec_data_w;
        check("s4_err", 256'(r.err), 256'(1));
        check("s4_perr_sticky", 256'(perr_w), 256'(1));

        // Start queue overflow on the fifth accept.
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            drive(c >= 1 && c <= 5, 0, 1, 0);
            tick();
            if (c == 4) check("s4_no_ovf", 256'(perr_w), 256'(0));
            if (c == 5) check("s4_ovf", 256'(perr_w), 256'(1));
        end

        // Record FIFO full: 19 records with the consumer stalled, then pop+push together.
        do_reset();
        for (int c = 0; c <= 40; c++) begin drive(c < 38 && c % 2 == 0, c < 38 && c % 2 == 1, 1, 0); tick(); end
        check("s5_drop", 256'(drop_w), 256'(3));
        for (int c = 41; c <= 46; c++) begin drive(c == 41, c == 42, 1, c == 43); tick(); end
        check("s5_no_drop", 256'(drop_w), 256'(3));
        for (int c = 0; c < 20; c++) begin drive(0, 0, 1, 1); tick(); end

        // Finish with two outstanding.
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            drive(c == 3 || c == 5, c == 12 || c == 14, 1, c >= 25);
            finish = (c == 7);
            tick();
            if (c == 20) check("s6_not_drained", 256'(drained_w), 256'(0));
        end
        check("s6_drained_w", 256'(drained_w), 256'(1));
        check("s6_drained_n", 256'(drained_n), 256'(1));

        // Counter wrap on the 8-bit instance: A at 250, D at 260 (cyc 4).
        do_reset();
        for (int c = 0; c <= 265; c++) begin drive(c == 250, c == 260, 1, 0); tick(); end
        check("s6_wrap_lat", 256'(rec_data_n[23:16]), 256'(10));
        check("s6_wrap_start", 256'(rec_data_n[31:24]), 256'(250));

        // Reset while active clears every output.
        do_reset();
        for (int c = 0; c <= 8; c++) begin drive(c == 3, c == 1, 1, 0); tick(); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("s6_rst_valid", 256'(rec_valid_w), 256'(0));
        check("s6_rst_data", 256'(rec_data_w), 256'(0));
        check("s6_rst_perr", 256'(perr_w), 256'(0));
        check("s6_rst_busy", 256'(busy_w), 256'(0));
        check("s6_rst_drop", 256'(drop_w), 256'(0));
        check("s6_rst_drained", 256'(drained_n), 256'(0));

        // Randomized traffic with occasional resets and consumer stall phases.
        for (int i = 0; i < 3000; i++) begin
            ap_start    = ($urandom_range(0, 2) == 0);
            ap_ready    = ($urandom_range(0, 3) != 0);
            ap_done     = ($urandom_range(0, 3) == 0);
            ap_continue = ($urandom_range(0, 3) != 0);
            rec_ready   = ((i / 300) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 1);
            reset       = ($urandom_range(0, 599) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
